// File: rtl/cake_pkg.sv
// Shared constants for the cake colour-select path: LFSR setup, colour codes
// and the producer FSM state encoding.
package cake_pkg;

    localparam int unsigned LFSR_W    = 16;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef logic [2:0] code_t;

    localparam code_t COL_BLUE   = 3'b001;
    localparam code_t COL_GREEN  = 3'b010;
    localparam code_t COL_RED    = 3'b011;
    localparam code_t COL_PURPLE = 3'b100;
    localparam code_t COL_ORANGE = 3'b101;
    localparam code_t COL_YELLOW = 3'b110;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } state_e;

    // One Galois step: shift right, fold the mask back in when the lsb falls out.
    function automatic logic [15:0] lfsr_next(input logic [15:0] v, input logic [15:0] taps);
        return v[0] ? ((v >> 1) ^ taps) : (v >> 1);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR with synchronous reset and parallel load.
module lfsr16
    import cake_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED,
    parameter logic [15:0] TAPS = LFSR_TAPS
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_val,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    always_comb begin
        lfsr_d = load ? load_val : lfsr_next(lfsr_q, TAPS);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/rand_num_gen.sv
// Colour-code producer: draws a 3-bit code from the LFSR on request, optionally
// rejecting repeats of the last issued code, and pulses valid on each issue.
module rand_num_gen
    import cake_pkg::*;
#(
    parameter logic [15:0] SEED      = LFSR_SEED,
    parameter logic [15:0] TAPS      = LFSR_TAPS,
    parameter int unsigned NO_REPEAT = 1,
    parameter int unsigned MAX_TRIES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    output logic [2:0]  randNum,
    output logic        valid,
    output logic        busy
);

    localparam logic [2:0] LAST_TRY = 3'(MAX_TRIES - 1);

    state_e      state_q, state_d;
    logic [2:0]  tries_q, tries_d;
    code_t       rand_num_q, rand_num_d;
    logic        valid_q, valid_d;
    logic [15:0] lfsr_val;
    logic [15:0] load_val;
    code_t       cand;
    logic        cand_ok;

    // A zero seed would lock the LFSR, so it is replaced by the default seed.
    assign load_val = (seed_in == 16'h0000) ? SEED : seed_in;

    lfsr16 #(
        .SEED(SEED),
        .TAPS(TAPS)
    ) u_lfsr (
        .clock    (clock),
        .reset    (reset),
        .load     (seed_load),
        .load_val (load_val),
        .out      (lfsr_val)
    );

    assign cand    = lfsr_val[2:0];
    assign cand_ok = (NO_REPEAT == 0) || (cand != rand_num_q);

    always_comb begin
        state_d    = state_q;
        tries_d    = tries_q;
        rand_num_d = rand_num_q;
        valid_d    = 1'b0;
        if (seed_load) begin
            state_d = ST_IDLE;
            tries_d = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        state_d = ST_DRAW;
                        tries_d = '0;
                    end
                end
                ST_DRAW: begin
                    if (cand_ok) begin
                        rand_num_d = cand;
                        valid_d    = 1'b1;
                        state_d    = ST_IDLE;
                    end else if (tries_q == LAST_TRY) begin
                        rand_num_d = rand_num_q + 3'd1;
                        valid_d    = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        tries_d = tries_q + 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tries_q    <= '0;
            rand_num_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tries_q    <= tries_d;
            rand_num_q <= rand_num_d;
            valid_q    <= valid_d;
        end
    end

    assign randNum = rand_num_q;
    assign valid   = valid_q;
    assign busy    = (state_q == ST_DRAW);

endmodule

// File: tb/tb_rand_num_gen.sv
// Bench for rand_num_gen: three parameter variants driven in parallel against a
// per-variant behavioural model, plus directed literal expectations.
module tb_rand_num_gen;

    localparam int NR [3] = '{1, 0, 1};
    localparam int MT [3] = '{4, 4, 1};

    logic        clock;
    logic        reset;
    logic        req;
    logic        seed_load;
    logic [15:0] seed_in;
    logic [2:0]  rn [3];
    logic        v  [3];
    logic        b  [3];
    logic [15:0] lf [3];

    int checks   = 0;
    int failures = 0;

    int m_lfsr  [3];
    int m_code  [3];
    int m_tries [3];
    bit m_busy  [3];
    bit m_valid [3];
    bit model_on = 1'b0;

    rand_num_gen #(.NO_REPEAT(1), .MAX_TRIES(4)) dut0 (
        .clock(clock), .reset(reset), .req(req), .seed_load(seed_load), .seed_in(seed_in),
        .randNum(rn[0]), .valid(v[0]), .busy(b[0]));
    rand_num_gen #(.NO_REPEAT(0), .MAX_TRIES(4)) dut1 (
        .clock(clock), .reset(reset), .req(req), .seed_load(seed_load), .seed_in(seed_in),
        .randNum(rn[1]), .valid(v[1]), .busy(b[1]));
    rand_num_gen #(.NO_REPEAT(1), .MAX_TRIES(1)) dut2 (
        .clock(clock), .reset(reset), .req(req), .seed_load(seed_load), .seed_in(seed_in),
        .randNum(rn[2]), .valid(v[2]), .busy(b[2]));

    assign lf[0] = dut0.lfsr_val;
    assign lf[1] = dut1.lfsr_val;
    assign lf[2] = dut2.lfsr_val;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_adv(input int x);
        return (x % 2 == 1) ? ((x / 2) ^ 'hB400) : (x / 2);
    endfunction

    // Model: a request waits for a candidate unequal to the last code; after
    // MT rejected draws the code simply advances by one (mod 8).
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            int cand;
            cand = m_lfsr[i] % 8;
            m_valid[i] <= 1'b0;
            if (reset) begin
                m_lfsr[i]  <= 'hACE1;
                m_code[i]  <= 0;
                m_tries[i] <= 0;
                m_busy[i]  <= 1'b0;
            end else if (seed_load) begin
                m_lfsr[i]  <= (seed_in == 0) ? 'hACE1 : int'(seed_in);
                m_tries[i] <= 0;
                m_busy[i]  <= 1'b0;
            end else begin
                m_lfsr[i] <= lfsr_adv(m_lfsr[i]);
                if (m_busy[i]) begin
                    if (NR[i] == 0 || cand != m_code[i]) begin
                        m_code[i]  <= cand;
                        m_valid[i] <= 1'b1;
                        m_busy[i]  <= 1'b0;
                    end else if (m_tries[i] + 1 >= MT[i]) begin
                        m_code[i]  <= (m_code[i] + 1) % 8;
                        m_valid[i] <= 1'b1;
                        m_busy[i]  <= 1'b0;
                    end else begin
                        m_tries[i] <= m_tries[i] + 1;
                    end
                end else if (req) begin
                    m_busy[i]  <= 1'b1;
                    m_tries[i] <= 0;
                end
            end
        end
        if (reset) model_on <= 1'b1;
    end

    always @(negedge clock) begin
        if (model_on) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("model_randNum%0d", i), int'(rn[i]), m_code[i]);
                chk($sformatf("model_valid%0d", i), int'(v[i]), int'(m_valid[i]));
                chk($sformatf("model_busy%0d", i), int'(b[i]), int'(m_busy[i]));
                chk($sformatf("model_lfsr%0d", i), int'(lf[i]), m_lfsr[i]);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        int cnt1;
        logic [2:0] prev0;
        reset = 1'b1; req = 1'b0; seed_load = 1'b0; seed_in = 16'h0000;
        tick(); tick();
        reset = 1'b0;
        chk("rst_randNum", int'(rn[0]), 0);
        chk("rst_valid", int'(v[0]), 0);
        chk("rst_busy", int'(b[0]), 0);
        chk("lfsr_c0", int'(lf[0]), 'hACE1);
        tick(); chk("lfsr_c1", int'(lf[0]), 'hE270);
        tick(); chk("lfsr_c2", int'(lf[0]), 'h7138);
        tick(); chk("lfsr_c3", int'(lf[0]), 'h389C);

        // first request straight after reset
        reset = 1'b1; tick();
        reset = 1'b0; req = 1'b1;
        tick(); req = 1'b0;
        for (int i = 0; i < 3; i++) chk($sformatf("e1_busy%0d", i), int'(b[i]), 1);
        tick();
        chk("e2_valid1", int'(v[1]), 1);
        chk("e2_randNum1", int'(rn[1]), 0);
        chk("e2_valid2_forced", int'(v[2]), 1);
        chk("e2_randNum2_forced", int'(rn[2]), 1);
        chk("e2_busy0", int'(b[0]), 1);
        chk("e2_valid0", int'(v[0]), 0);
        tick();
        chk("e3_busy0", int'(b[0]), 1);
        chk("e3_valid0", int'(v[0]), 0);
        tick();
        chk("e4_valid0", int'(v[0]), 1);
        chk("e4_randNum0", int'(rn[0]), 4);
        chk("e4_busy0", int'(b[0]), 0);
        tick();
        chk("e5_valid0", int'(v[0]), 0);
        chk("e5_randNum0", int'(rn[0]), 4);

        // seed loads, zero seed replaced by default
        seed_load = 1'b1; seed_in = 16'h0000; tick();
        chk("seed_zero", int'(lf[0]), 'hACE1);
        seed_in = 16'h1234; tick();
        chk("seed_1234", int'(lf[0]), 'h1234);
        seed_in = 16'h000E; tick();
        chk("seed_000e", int'(lf[2]), 'h000E);
        seed_load = 1'b0; req = 1'b1; tick();
        req = 1'b0; tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("seven_valid%0d", i), int'(v[i]), 1);
            chk($sformatf("seven_randNum%0d", i), int'(rn[i]), 7);
        end

        // same candidate 7 again: repeat allowed, wrapped, or rejected
        seed_load = 1'b1; seed_in = 16'h000E; tick();
        seed_load = 1'b0; req = 1'b1; tick();
        req = 1'b0; tick();
        chk("rep_valid1", int'(v[1]), 1);
        chk("rep_randNum1", int'(rn[1]), 7);
        chk("wrap_valid2", int'(v[2]), 1);
        chk("wrap_randNum2", int'(rn[2]), 0);
        chk("rej_busy0", int'(b[0]), 1);
        chk("rej_valid0", int'(v[0]), 0);
        repeat (6) tick();

        // seed load mid-draw drops the request
        req = 1'b1; tick();
        req = 1'b0; seed_load = 1'b1; seed_in = 16'h5555; tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sl_busy%0d", i), int'(b[i]), 0);
            chk($sformatf("sl_valid%0d", i), int'(v[i]), 0);
        end
        chk("sl_lfsr", int'(lf[0]), 'h5555);
        seed_load = 1'b0;

        // reset mid-draw, then reset together with seed_load
        req = 1'b1; tick();
        req = 1'b0; reset = 1'b1; tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rd_randNum%0d", i), int'(rn[i]), 0);
            chk($sformatf("rd_valid%0d", i), int'(v[i]), 0);
            chk($sformatf("rd_busy%0d", i), int'(b[i]), 0);
        end
        seed_load = 1'b1; seed_in = 16'h1234; tick();
        chk("rst_beats_seed", int'(lf[0]), 'hACE1);
        reset = 1'b0; seed_load = 1'b0;

        // req held high continuously
        cnt1 = 0;
        prev0 = rn[0];
        req = 1'b1;
        repeat (40) begin
            tick();
            if (v[1]) cnt1 = cnt1 + 1;
            if (v[0]) begin
                chk("norepeat0", int'(rn[0] != prev0), 1);
                prev0 = rn[0];
            end
        end
        req = 1'b0;
        chk("b2b_count1", cnt1, 20);
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
